irq_ctrl: RTL and testbench

Interrupt controller that owns the `interrupt[3:0]` input of the write-back stage's CSR unit. It synchronizes four external interrupt sources and latches them as pending, either edge- or level-sensitive per source. It masks the pending set, picks one by fixed priority and presents it as a stable one-hot request until the CSR unit reports the trap taken. It then blocks further requests until `mret` retires; nesting is not supported.

---
 rtl/irq_pkg.sv | 8 +
 rtl/irq_sync.sv | 28 ++
 rtl/irq_ctrl.sv | 104 ++++++++++
 tb/tb_irq_ctrl.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/irq_pkg.sv
// Shared types for the interrupt controller: FSM state encoding and default source count.
package irq_pkg;

    typedef enum logic [1:0] {IDLE, REQ, SERVICE} irq_state_t;

    localparam int NUM_IRQ_DEF = 4;

endpackage

// File: rtl/irq_sync.sv
// Per-source synchronizer plus previous-value flop; rise marks a synchronized 0->1 transition.
module irq_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic src,
    output logic s,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sff;
    logic                   s_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sff <= '0;
            s_q <= 1'b0;
        end else begin
            sff <= {sff[SYNC_STAGES-2:0], src};
            s_q <= sff[SYNC_STAGES-1];
        end
    end

    assign s    = sff[SYNC_STAGES-1];
    assign rise = s & ~s_q;

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: pending latch, fixed-priority pick (lowest index wins) and
// IDLE/REQ/SERVICE handshake with the CSR unit. Nested interrupts are not supported.
module irq_ctrl
    import irq_pkg::*;
#(
    parameter int NUM_IRQ     = NUM_IRQ_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_IRQ-1:0]         irq_src,
    input  logic [NUM_IRQ-1:0]         edge_mode,
    input  logic [NUM_IRQ-1:0]         irq_en,
    input  logic                       global_en,
    input  logic [NUM_IRQ-1:0]         clr,
    input  logic                       trap_taken,
    input  logic                       is_mret,
    output logic [NUM_IRQ-1:0]         irq_out,
    output logic [$clog2(NUM_IRQ)-1:0] irq_id,
    output logic [NUM_IRQ-1:0]         pending,
    output logic                       in_service
);

    localparam int IDW = $clog2(NUM_IRQ);

    logic [NUM_IRQ-1:0] s, rise;
    logic [NUM_IRQ-1:0] pend_edge, pend_edge_n;
    logic [NUM_IRQ-1:0] eligible, out_n;
    logic [IDW-1:0]     winner, id_n;
    logic               tt_req, clr_hit;
    irq_state_t         state, state_n;

    irq_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync [NUM_IRQ-1:0] (
        .clk  (clk),
        .rst  (rst),
        .src  (irq_src),
        .s    (s),
        .rise (rise)
    );

    assign tt_req = (state == REQ) && trap_taken;

    // Edge bits only; a rise in the same cycle as a clear keeps the bit set.
    always_comb begin
        pend_edge_n = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            pend_edge_n[i] = edge_mode[i] &
                             (rise[i] | (pend_edge[i] & ~(clr[i] | (tt_req && irq_id == IDW'(i)))));
        end
    end

    // Level sources read the synchronizer flop directly so they are not delayed a cycle.
    assign pending  = pend_edge | (s & ~edge_mode);
    assign eligible = global_en ? (pending & irq_en) : '0;

    always_comb begin
        winner = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (eligible[i]) winner = IDW'(i);
        end
    end

    // clr lands on the pending flop at this edge, so treat it as an immediate withdraw.
    assign clr_hit = clr[irq_id] & edge_mode[irq_id] & ~rise[irq_id];

    always_comb begin
        state_n = state;
        id_n    = irq_id;
        case (state)
            IDLE: begin
                if (|eligible) begin
                    state_n = REQ;
                    id_n    = winner;
                end
            end
            REQ: begin
                if (trap_taken)                         state_n = SERVICE;
                else if (!eligible[irq_id] || clr_hit)  state_n = IDLE;
            end
            SERVICE: begin
                if (is_mret) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        out_n = (state_n == REQ) ? ({{(NUM_IRQ-1){1'b0}}, 1'b1} << id_n) : '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            irq_id     <= '0;
            irq_out    <= '0;
            in_service <= 1'b0;
            pend_edge  <= '0;
        end else begin
            state      <= state_n;
            irq_id     <= id_n;
            irq_out    <= out_n;
            in_service <= (state_n == SERVICE);
            pend_edge  <= pend_edge_n;
        end
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: expectations queued at stimulus time, popped and asserted on sampling.
module tb_irq_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] irq_src, edge_mode, irq_en, clr;
    logic       global_en, trap_taken, is_mret;
    logic [3:0] irq_out, pending;
    logic [1:0] irq_id;
    logic       in_service;

    typedef struct {
        string      tag;
        logic [3:0] out;
        logic [1:0] id;
        logic [3:0] pend;
        logic       svc;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    irq_ctrl #(.NUM_IRQ(4), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .irq_src    (irq_src),
        .edge_mode  (edge_mode),
        .irq_en     (irq_en),
        .global_en  (global_en),
        .clr        (clr),
        .trap_taken (trap_taken),
        .is_mret    (is_mret),
        .irq_out    (irq_out),
        .irq_id     (irq_id),
        .pending    (pending),
        .in_service (in_service)
    );

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_exp(input string tag, input logic [3:0] o, input logic [1:0] id,
                            input logic [3:0] p, input logic sv);
        exp_t e;
        e.tag = tag; e.out = o; e.id = id; e.pend = p; e.svc = sv;
        sb.push_back(e);
    endtask

    task automatic cmp(input string tag, input string f, input logic [3:0] obs, input logic [3:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s.%s observed=%h expected=%h", tag, f, obs, exp);
        end
    endtask

    task automatic check();
        exp_t e;
        if (sb.size() == 0) begin
            n_assert++;
            n_fail++;
            $display("FAIL scoreboard_empty observed=0 expected=1 entries");
            return;
        end
        e = sb.pop_front();
        cmp(e.tag, "irq_out",    irq_out,              e.out);
        cmp(e.tag, "irq_id",     {2'b00, irq_id},      {2'b00, e.id});
        cmp(e.tag, "pending",    pending,              e.pend);
        cmp(e.tag, "in_service", {3'b000, in_service}, {3'b000, e.svc});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0; irq_src = '0; edge_mode = 4'b0100; irq_en = 4'hF; clr = '0;
        global_en = 1'b1; trap_taken = 1'b0; is_mret = 1'b0;

        // Reset state
        push_exp("reset", 4'h0, 2'd0, 4'h0, 1'b0);
        tick(2); check();
        rst = 1'b1;
        tick(2);

        // Edge on source 2, full trap/mret round trip
        irq_src[2] = 1'b1;
        push_exp("e2_pend", 4'h0, 2'd0, 4'b0100, 1'b0);
        tick(3); check();
        push_exp("e2_req", 4'b0100, 2'd2, 4'b0100, 1'b0);
        tick(1); check();
        irq_src[2] = 1'b0; trap_taken = 1'b1;
        push_exp("e2_trap", 4'h0, 2'd2, 4'h0, 1'b1);
        tick(1); check();
        trap_taken = 1'b0; is_mret = 1'b1;
        push_exp("e2_mret", 4'h0, 2'd2, 4'h0, 1'b0);
        tick(1); check();
        is_mret = 1'b0;
        tick(3);

        // Simultaneous edges on 1 and 3: 1 first, 3 afterwards without a new edge
        edge_mode = 4'b1110;
        irq_src[1] = 1'b1; irq_src[3] = 1'b1;
        push_exp("e13_pend", 4'h0, 2'd2, 4'b1010, 1'b0);
        tick(3); check();
        push_exp("e13_req1", 4'b0010, 2'd1, 4'b1010, 1'b0);
        tick(1); check();
        irq_src[1] = 1'b0; irq_src[3] = 1'b0; trap_taken = 1'b1;
        push_exp("e13_trap1", 4'h0, 2'd1, 4'b1000, 1'b1);
        tick(1); check();
        trap_taken = 1'b0; is_mret = 1'b1;
        push_exp("e13_mret1", 4'h0, 2'd1, 4'b1000, 1'b0);
        tick(1); check();
        is_mret = 1'b0;
        push_exp("e13_req3", 4'b1000, 2'd3, 4'b1000, 1'b0);
        tick(1); check();
        trap_taken = 1'b1;
        push_exp("e13_trap3", 4'h0, 2'd3, 4'h0, 1'b1);
        tick(1); check();
        trap_taken = 1'b0; is_mret = 1'b1;
        push_exp("e13_mret3", 4'h0, 2'd3, 4'h0, 1'b0);
        tick(1); check();
        is_mret = 1'b0;
        tick(3);

        // Level source 0 raised then dropped before trap: withdraw
        irq_src[0] = 1'b1;
        push_exp("lvl_pend", 4'h0, 2'd3, 4'b0001, 1'b0);
        tick(2); check();
        push_exp("lvl_req", 4'b0001, 2'd0, 4'b0001, 1'b0);
        tick(1); check();
        irq_src[0] = 1'b0;
        push_exp("lvl_hold1", 4'b0001, 2'd0, 4'b0001, 1'b0);
        tick(1); check();
        push_exp("lvl_hold2", 4'b0001, 2'd0, 4'b0000, 1'b0);
        tick(1); check();
        push_exp("lvl_withdraw", 4'h0, 2'd0, 4'h0, 1'b0);
        tick(1); check();
        tick(2);

        // Source 1 edge coincides with clr[1]; global_en gates the request
        global_en = 1'b0;
        irq_src[1] = 1'b1;
        tick(2);
        clr = 4'b0010;
        push_exp("clr_setwins", 4'h0, 2'd0, 4'b0010, 1'b0);
        tick(1); check();
        clr = '0; irq_src[1] = 1'b0;
        push_exp("gen_off", 4'h0, 2'd0, 4'b0010, 1'b0);
        tick(3); check();
        global_en = 1'b1;
        push_exp("gen_on", 4'b0010, 2'd1, 4'b0010, 1'b0);
        tick(1); check();
        clr = 4'b0010;
        push_exp("clr_withdraw", 4'h0, 2'd1, 4'h0, 1'b0);
        tick(1); check();
        clr = '0;
        tick(2);

        // Edge on source 0 during SERVICE of source 2
        edge_mode = 4'b1111;
        irq_src[2] = 1'b1;
        push_exp("svc_req2", 4'b0100, 2'd2, 4'b0100, 1'b0);
        tick(4); check();
        trap_taken = 1'b1; irq_src[2] = 1'b0;
        push_exp("svc_trap2", 4'h0, 2'd2, 4'h0, 1'b1);
        tick(1); check();
        trap_taken = 1'b0; irq_src[0] = 1'b1;
        push_exp("svc_e0_blocked", 4'h0, 2'd2, 4'b0001, 1'b1);
        tick(3); check();
        is_mret = 1'b1;
        push_exp("svc_mret2", 4'h0, 2'd2, 4'b0001, 1'b0);
        tick(1); check();
        is_mret = 1'b0;
        push_exp("svc_req0", 4'b0001, 2'd0, 4'b0001, 1'b0);
        tick(1); check();
        trap_taken = 1'b1;
        push_exp("svc_trap0", 4'h0, 2'd0, 4'h0, 1'b1);
        tick(1); check();
        trap_taken = 1'b0; is_mret = 1'b1;
        push_exp("svc_mret0", 4'h0, 2'd0, 4'h0, 1'b0);
        tick(1); check();
        is_mret = 1'b0; trap_taken = 1'b1;
        push_exp("trap_in_idle", 4'h0, 2'd0, 4'h0, 1'b0);
        tick(1); check();
        trap_taken = 1'b0;
        push_exp("idle_after_trap", 4'h0, 2'd0, 4'h0, 1'b0);
        tick(1); check();
        irq_src[0] = 1'b0;
        tick(3);

        // Asynchronous reset while in REQ
        irq_src[3] = 1'b1;
        push_exp("rst_pre_req", 4'b1000, 2'd3, 4'b1000, 1'b0);
        tick(4); check();
        rst = 1'b0; irq_src[3] = 1'b0;
        push_exp("rst_async", 4'h0, 2'd0, 4'h0, 1'b0);
        #2; check();
        tick(1);
        rst = 1'b1;
        push_exp("rst_quiet", 4'h0, 2'd0, 4'h0, 1'b0);
        tick(6); check();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
